fetch_ctrl: RTL and testbench

Sequencing controller for the instruction-fetch stage. It owns the fetch PC and drives a request/acknowledge handshake to instruction memory, which may have variable latency. It delivers one instruction per cycle into a decode-side holding register and honours the downstream stall. It applies branch redirects (PCSrc_F/PCBranch_F), including discarding stale responses for requests already in flight.

---
 rtl/fetch_ctrl.sv | 105 ++++++++++
 tb/tb_fetch_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// ============================================================================
// fetch_ctrl : instruction-fetch sequencer with req/ack memory handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_ctrl #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          ALIGN_MASK = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrc_F,
  input  logic [63:0] PCBranch_F,
  input  logic        stall_D,
  output logic        imem_req,
  output logic [63:0] imem_addr_F,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid_D,
  output logic [31:0] instr_D,
  output logic [63:0] pc_D
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_FETCH = 2'd1;
  localparam logic [1:0] c_FLUSH = 2'd2;

  logic [1:0]  r_state;
  logic [63:0] r_fetch_pc;
  logic [63:0] r_redirect_pc;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [63:0] r_pc;

  logic        w_slot_free;
  logic        w_accept;
  logic        w_req;
  logic [63:0] w_target;

  assign w_slot_free = ~r_valid | ~stall_D;
  assign w_accept    = r_valid & ~stall_D;
  assign w_req       = (r_state == c_FETCH) ? w_slot_free : (r_state == c_FLUSH);
  assign w_target    = (ALIGN_MASK != 0) ? {PCBranch_F[63:2], 2'b00} : PCBranch_F;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= c_IDLE;
      r_fetch_pc    <= RESET_PC;
      r_redirect_pc <= 64'h0;
      r_valid       <= 1'b0;
      r_instr       <= 32'h0;
      r_pc          <= 64'h0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_state <= c_FETCH;
          r_valid <= 1'b0;
          if (PCSrc_F) r_fetch_pc <= w_target;
        end
        c_FETCH: begin
          if (PCSrc_F) begin
            r_valid <= 1'b0;
            // A request still waiting on memory cannot be re-addressed; park the target.
            if (!w_req || imem_ack) begin
              r_fetch_pc <= w_target;
            end else begin
              r_redirect_pc <= w_target;
              r_state       <= c_FLUSH;
            end
          end else if (w_req && imem_ack) begin
            r_instr    <= imem_rdata;
            r_pc       <= r_fetch_pc;
            r_valid    <= 1'b1;
            r_fetch_pc <= r_fetch_pc + 64'd4;
          end else if (w_accept) begin
            r_valid <= 1'b0;
          end
        end
        c_FLUSH: begin
          r_valid <= 1'b0;
          if (imem_ack) begin
            r_state    <= c_FETCH;
            r_fetch_pc <= PCSrc_F ? w_target : r_redirect_pc;
          end else if (PCSrc_F) begin
            r_redirect_pc <= w_target;
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req      = w_req;
  assign imem_addr_F   = r_fetch_pc;
  assign instr_valid_D = r_valid;
  assign instr_D       = r_instr;
  assign pc_D          = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// tb_fetch_ctrl : directed self-checking bench for fetch_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCSrc_F;
  logic [63:0] PCBranch_F;
  logic        stall_D;
  logic        imem_req;
  logic [63:0] imem_addr_F;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid_D;
  logic [31:0] instr_D;
  logic [63:0] pc_D;
  logic        ack_tie;
  logic        ack_man;

  logic        PCSrc2;
  logic [63:0] PCBranch2;
  logic        imem_req2;
  logic [63:0] imem_addr2;
  logic [31:0] imem_rdata2;
  logic        instr_valid2;
  logic [31:0] instr2;
  logic [63:0] pc2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_ack    = ack_tie ? imem_req : ack_man;
  assign imem_rdata  = imem_addr_F[31:0] ^ 32'hDEAD_0000;
  assign imem_rdata2 = imem_addr2[31:0] ^ 32'hBEEF_0000;

  fetch_ctrl #(.RESET_PC(64'h0), .ALIGN_MASK(1)) u_dut (
    .clk(clk), .reset(reset), .PCSrc_F(PCSrc_F), .PCBranch_F(PCBranch_F),
    .stall_D(stall_D), .imem_req(imem_req), .imem_addr_F(imem_addr_F),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid_D(instr_valid_D),
    .instr_D(instr_D), .pc_D(pc_D)
  );

  fetch_ctrl #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .ALIGN_MASK(0)) u_dut2 (
    .clk(clk), .reset(reset), .PCSrc_F(PCSrc2), .PCBranch_F(PCBranch2),
    .stall_D(1'b0), .imem_req(imem_req2), .imem_addr_F(imem_addr2),
    .imem_ack(imem_req2), .imem_rdata(imem_rdata2), .instr_valid_D(instr_valid2),
    .instr_D(instr2), .pc_D(pc2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; PCSrc_F = 1'b0; PCBranch_F = 64'h0; stall_D = 1'b0;
    ack_tie = 1'b1; ack_man = 1'b0; PCSrc2 = 1'b0; PCBranch2 = 64'h0;
    #2;
    chk("rst_req",   {63'h0, imem_req}, 64'h0);
    chk("rst_valid", {63'h0, instr_valid_D}, 64'h0);
    chk("rst_instr", {32'h0, instr_D}, 64'h0);
    chk("rst_pc",    pc_D, 64'h0);
    chk("rst_addr",  imem_addr_F, 64'h0);
    chk("rst_addr2", imem_addr2, 64'hFFFF_FFFF_FFFF_FFFC);

    nxt(); reset = 1'b0; #1;                       // t=11, IDLE
    chk("idle_req", {63'h0, imem_req}, 64'h0);
    nxt();                                         // t=20
    chk("fetch0_req",  {63'h0, imem_req}, 64'h1);
    chk("fetch0_addr", imem_addr_F, 64'h0);
    nxt();                                         // t=30
    chk("fetch1_addr",  imem_addr_F, 64'h4);
    chk("fetch1_valid", {63'h0, instr_valid_D}, 64'h1);
    chk("fetch1_pc",    pc_D, 64'h0);
    chk("fetch1_instr", {32'h0, instr_D}, 64'hDEAD_0000);
    chk("wrap_addr2",   imem_addr2, 64'h0);
    chk("wrap_pc2",     pc2, 64'hFFFF_FFFF_FFFF_FFFC);
    PCSrc2 = 1'b1; PCBranch2 = 64'h303;
    nxt();                                         // t=40
    PCSrc2 = 1'b0;
    chk("noalign_addr2", imem_addr2, 64'h303);
    chk("fetch2_pc",     pc_D, 64'h4);
    chk("fetch2_addr",   imem_addr_F, 64'h8);
    nxt();                                         // t=50
    chk("fetch3_pc",   pc_D, 64'h8);
    chk("fetch3_addr", imem_addr_F, 64'hC);

    stall_D = 1'b1; #1;
    chk("stall_req", {63'h0, imem_req}, 64'h0);
    nxt(); nxt(); nxt();                           // t=80, three stalled edges
    chk("stall_pc",    pc_D, 64'h8);
    chk("stall_instr", {32'h0, instr_D}, 64'hDEAD_0008);
    chk("stall_valid", {63'h0, instr_valid_D}, 64'h1);
    chk("stall_addr",  imem_addr_F, 64'hC);
    stall_D = 1'b0; #1;
    chk("unstall_req", {63'h0, imem_req}, 64'h1);
    nxt();                                         // t=90
    chk("unstall_pc",   pc_D, 64'hC);
    chk("unstall_addr", imem_addr_F, 64'h10);

    PCSrc_F = 1'b1; PCBranch_F = 64'h100;          // redirect with ack for 0x10
    nxt();                                         // t=100
    PCSrc_F = 1'b0;
    chk("redir_valid", {63'h0, instr_valid_D}, 64'h0);
    chk("redir_addr",  imem_addr_F, 64'h100);
    chk("redir_pc",    pc_D, 64'hC);
    nxt();                                         // t=110
    chk("redir_pc2",    pc_D, 64'h100);
    chk("redir_instr2", {32'h0, instr_D}, 64'hDEAD_0100);

    PCSrc_F = 1'b1; PCBranch_F = 64'h20;
    nxt();                                         // t=120
    PCSrc_F = 1'b0; ack_tie = 1'b0; ack_man = 1'b0;
    chk("lat_addr0", imem_addr_F, 64'h20);
    nxt();                                         // t=130
    PCSrc_F = 1'b1; PCBranch_F = 64'h200;
    nxt();                                         // t=140, now in FLUSH
    PCSrc_F = 1'b0;
    chk("flush_req",   {63'h0, imem_req}, 64'h1);
    chk("flush_addr",  imem_addr_F, 64'h20);
    chk("flush_valid", {63'h0, instr_valid_D}, 64'h0);
    ack_man = 1'b1;
    nxt();                                         // t=150
    ack_man = 1'b0;
    chk("flush_done_addr",  imem_addr_F, 64'h200);
    chk("flush_done_valid", {63'h0, instr_valid_D}, 64'h0);
    ack_man = 1'b1;
    nxt();                                         // t=160
    ack_man = 1'b0;
    chk("post_flush_pc",    pc_D, 64'h200);
    chk("post_flush_instr", {32'h0, instr_D}, 64'hDEAD_0200);
    chk("post_flush_addr",  imem_addr_F, 64'h204);

    PCSrc_F = 1'b1; PCBranch_F = 64'h500;
    nxt();                                         // t=170, FLUSH
    chk("flush2_addr", imem_addr_F, 64'h204);
    PCBranch_F = 64'h303;                          // latest wins, aligned to 0x300
    nxt();                                         // t=180
    PCSrc_F = 1'b0;
    chk("flush2_hold", imem_addr_F, 64'h204);
    ack_man = 1'b1;
    nxt();                                         // t=190
    chk("flush2_target", imem_addr_F, 64'h300);
    chk("flush2_valid",  {63'h0, instr_valid_D}, 64'h0);
    chk("flush2_drop",   {32'h0, instr_D}, 64'hDEAD_0200);
    nxt();                                         // t=200
    ack_man = 1'b0;
    chk("flush2_pc", pc_D, 64'h300);

    PCSrc_F = 1'b1; PCBranch_F = 64'h400;
    nxt();                                         // t=210, FLUSH
    PCBranch_F = 64'h600; ack_man = 1'b1;          // redirect coincident with FLUSH ack
    nxt();                                         // t=220
    PCSrc_F = 1'b0; ack_man = 1'b0;
    chk("flush_ack_redir", imem_addr_F, 64'h600);

    PCSrc_F = 1'b1; PCBranch_F = 64'h700;
    nxt();                                         // t=230, FLUSH
    PCSrc_F = 1'b0;
    chk("pre_rst_req", {63'h0, imem_req}, 64'h1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_req",   {63'h0, imem_req}, 64'h0);
    chk("async_rst_valid", {63'h0, instr_valid_D}, 64'h0);
    chk("async_rst_addr",  imem_addr_F, 64'h0);
    chk("async_rst_pc",    pc_D, 64'h0);
    chk("async_rst_addr2", imem_addr2, 64'hFFFF_FFFF_FFFF_FFFC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
